// File: rtl/btn_debounce_onehot_pkg.sv
// Shared types and defaults for the push-button debounce/one-hot encoder.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
//
// Contents: FSM state enum, default button count and debounce length, and
// onehot_msb(), which keeps only the highest set bit of a vector.
package btn_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } btn_state_t;

    localparam int N_BTN_DEFAULT    = 4;
    localparam int DEBOUNCE_DEFAULT = 500000;

    // Fixed working width so one function serves any button count up to 32.
    // Callers zero-extend their vector in and truncate the result back.
    localparam int ONEHOT_W = 32;

    // Highest set bit wins, so simultaneous presses favour the top button.
    function automatic logic [ONEHOT_W-1:0] onehot_msb(input logic [ONEHOT_W-1:0] v);
        logic [ONEHOT_W-1:0] r;
        r = '0;
        for (int i = 0; i < ONEHOT_W; i++) begin
            if (v[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce_onehot_if.sv
// Signal bundle between the button pads and the button capture register.
// Latency: n/a (wiring only).
// Backpressure: none; we is a single-cycle strobe with no ready return.
//
// Ports: btn_raw (raw pads in), botones (one-hot code), we (event strobe),
// btn_stable (debounced levels). master = the debouncer, slave = its user.
interface btn_debounce_onehot_if
    import btn_pkg::*;
#(
    parameter int N_BTN = N_BTN_DEFAULT
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] botones;
    logic             we;
    logic [N_BTN-1:0] btn_stable;

    modport master (
        input  btn_raw,
        output botones,
        output we,
        output btn_stable
    );

    modport slave (
        output btn_raw,
        input  botones,
        input  we,
        input  btn_stable
    );
endinterface

// File: rtl/btn_debounce_onehot_debounce_bit.sv
// One button: 2-flop synchronizer, consecutive-mismatch counter, stable flop.
// Latency: o_stable follows a clean i_raw change DEBOUNCE_CYCLES+1 edges after first sample.
// Backpressure: none; free-running per-bit filter.
//
// Ports: clk, reset_n (async active-low), i_raw (asynchronous pad),
// o_stable (debounced level).
module btn_debounce_bit
    import btn_pkg::*;
#(
    parameter  int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_raw,
    output logic o_stable
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_stable;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            // Any cycle agreeing with the stable level restarts the count,
            // so only an unbroken run of DEBOUNCE_CYCLES mismatches is accepted.
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_stable = r_stable;

endmodule

// File: rtl/btn_debounce_onehot.sv
// Debounces N_BTN raw buttons and turns each press gesture into one we strobe + one-hot code.
// Latency: clean press sampled at edge k -> btn_stable after k+1+DEBOUNCE_CYCLES, we after k+2+DEBOUNCE_CYCLES.
// Backpressure: none; we is a one-cycle strobe, botones holds until the next event.
//
// Ports: clk, reset_n (async active-low), bus (master modport: btn_raw in;
// botones, we, btn_stable out).
// Optional build macro BTN_AUTOREPEAT_EN: re-pulses we every REPEAT_CYCLES
// while the selected button stays held.
module btn_debounce_onehot
    import btn_pkg::*;
#(
    parameter int N_BTN           = N_BTN_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
`ifdef BTN_AUTOREPEAT_EN
    ,
    parameter int REPEAT_CYCLES   = 25000000
`endif
) (
    input  logic                  clk,
    input  logic                  reset_n,
    btn_debounce_onehot_if.master bus
);

    logic [N_BTN-1:0] w_stable;
    logic [N_BTN-1:0] r_stable_q;
    logic [N_BTN-1:0] w_rise;
    logic [N_BTN-1:0] w_pick;

    btn_state_t       r_state;
    btn_state_t       w_state_nxt;
    logic [N_BTN-1:0] r_botones;
    logic [N_BTN-1:0] w_botones_nxt;
    logic             r_we;
    logic             w_we_nxt;

`ifdef BTN_AUTOREPEAT_EN
    localparam int               RPT_W   = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RPT_W-1:0] RPT_MAX = RPT_W'(REPEAT_CYCLES - 1);

    logic [RPT_W-1:0] r_rpt_cnt;
    logic [RPT_W-1:0] w_rpt_nxt;
`endif

    genvar g;
    generate
        for (g = 0; g < N_BTN; g++) begin : g_bit
            btn_debounce_bit #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_bit (
                .clk      (clk),
                .reset_n  (reset_n),
                .i_raw    (bus.btn_raw[g]),
                .o_stable (w_stable[g])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stable_q <= '0;
        end else begin
            r_stable_q <= w_stable;
        end
    end

    // Rising edges of the debounced levels only; releases never create events.
    assign w_rise = w_stable & ~r_stable_q;
    assign w_pick = N_BTN'(onehot_msb(ONEHOT_W'(w_rise)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_botones <= '0;
            r_we      <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            r_rpt_cnt <= '0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_botones <= w_botones_nxt;
            r_we      <= w_we_nxt;
`ifdef BTN_AUTOREPEAT_EN
            r_rpt_cnt <= w_rpt_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_botones_nxt = r_botones;
        w_we_nxt      = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        w_rpt_nxt     = '0;
`endif
        case (r_state)
            IDLE: begin
                if (|w_rise) begin
                    w_botones_nxt = w_pick;
                    w_we_nxt      = 1'b1;
                    w_state_nxt   = HELD;
                end
            end
            HELD: begin
                // Stay here (swallowing any further rises) until every
                // button is released, so one gesture yields one event.
                if (w_stable == '0) begin
                    w_state_nxt = IDLE;
                end
`ifdef BTN_AUTOREPEAT_EN
                else if (|(w_stable & r_botones)) begin
                    if (r_rpt_cnt == RPT_MAX) begin
                        w_we_nxt  = 1'b1;
                        w_rpt_nxt = '0;
                    end else begin
                        w_rpt_nxt = r_rpt_cnt + RPT_W'(1);
                    end
                end
`endif
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.botones    = r_botones;
    assign bus.we         = r_we;
    assign bus.btn_stable = w_stable;

endmodule

// File: doc/btn_debounce_onehot.md
Name: btn_debounce_onehot

Overview:
- Upstream conditioning stage for the button capture register.
- Takes raw, asynchronous, bouncing push-button inputs and synchronizes and debounces each one.
- Reduces each press gesture to a single one-hot code on botones plus a one-cycle we strobe. The downstream register latches the 2-bit button index on that strobe.
- Guarantees botones is exactly one-hot, or all-zero, whenever we is high.

Parameters:
- N_BTN, 4: number of buttons. The downstream register requires 4.
- DEBOUNCE_CYCLES, 500000: consecutive cycles a synchronized input must differ from its stable value before it is accepted (10 ms at 50 MHz). Must be ≥ 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES): debounce counter width. Derived; not to be overridden.

Ports:
- clk, input, 1: single system clock. All flops on posedge clk.
- reset_n, input, 1: asynchronous, active-low reset (asserts immediately, deasserts on clk).
- btn_raw, input, N_BTN: raw pad inputs, 1 = pressed, asynchronous to clk.
- botones, output, N_BTN: registered one-hot code of the last accepted press. Bit 3 = button 1 … bit 0 = button 4.
- we, output, 1: one-cycle strobe; botones is valid and one-hot in this cycle.
- btn_stable, output, N_BTN: debounced level of each button, for status/LEDs.

Behaviour:
- Reset (reset_n=0):
  - All synchronizer flops, counters, btn_stable, botones and we are cleared to 0.
  - FSM goes to IDLE.
  - Effect is immediate, including mid-count or mid-pulse; we drops the same instant.
- Synchronizer: 2-flop chain per bit; the output of the second flop is sync[i].
- Debounce, per bit:
  - If sync[i]==btn_stable[i], cnt[i]<=0.
  - Else, if cnt[i]==DEBOUNCE_CYCLES-1, then btn_stable[i]<=sync[i] and cnt[i]<=0.
  - Else cnt[i]<=cnt[i]+1.
  - A glitch shorter than DEBOUNCE_CYCLES clears the counter and is never accepted.
  - Press and release are debounced identically.
- Rise detect: rise[i] = btn_stable[i] & ~stable_q[i], where stable_q is btn_stable delayed one cycle.
- FSM:
  - IDLE: if any rise[i], then:
    - botones <= one-hot of the highest-index bit set in rise. Simultaneous presses resolve in favour of bit 3.
    - we <= 1.
    - Go to HELD.
  - HELD:
    - we <= 0.
    - New rises are ignored; no events are generated while any button is held.
    - Return to IDLE when btn_stable == 0 (all released).
    - A second button pressed while the first is held produces no event, even after the first is released, unless all buttons reach 0 in between.
- botones holds its value between events; it never returns to 0 except on reset.
- Latency: btn_raw rising at the sample of edge k with no bounce gives btn_stable at edge k+1+DEBOUNCE_CYCLES and we high after edge k+2+DEBOUNCE_CYCLES, for exactly one cycle.
- we never asserts on two consecutive cycles, and never on a release.

Optional Feature:
- BTN_AUTOREPEAT_EN defined:
  - Adds parameter REPEAT_CYCLES (default 25000000).
  - In HELD, a repeat counter runs while the originally selected button remains stable-high. Every REPEAT_CYCLES cycles it re-pulses we for one cycle with unchanged botones.
  - The counter clears on entering HELD and on reset.
- BTN_AUTOREPEAT_EN undefined: no repeat logic is synthesized; behaviour is exactly as above.

Decomposition:
- Package btn_pkg contains:
  - typedef enum logic {IDLE, HELD} btn_state_t.
  - localparam N_BTN_DEFAULT = 4.
  - localparam DEBOUNCE_DEFAULT = 500000.
  - A function onehot_msb(logic [N_BTN-1:0]) returning the highest set bit as one-hot.
- Sub-module btn_debounce_bit holds the 2-flop synchronizer, counter and stable flop for one input. It is instantiated N_BTN times via generate.
- The top level holds rise detect, priority select and the FSM.

Test Plan (DEBOUNCE_CYCLES=4):
- Hold reset_n=0 with btn_raw=4'b1111: botones=0, we=0, btn_stable=0. On release, no we until the debounce completes.
- btn_raw=4'b0100, held clean, sampled at edge 1: btn_stable[2]=1 after edge 6; we=1 only after edge 7 with botones=4'b0100; we=0 after edge 8.
- btn_raw[0] pulses high for 3 cycles, then low: btn_stable stays 0, and no we ever asserts.
- btn_raw=4'b1001 rising simultaneously: one we with botones=4'b1000, then no further we until all buttons are released and a new press occurs.
- Press bit 1, then press bit 3 while bit 1 is still held, then release both: a single we with botones=4'b0010; botones remains 4'b0010 afterwards.
- Drop reset_n during the cycle in which we=1: we and botones go to 0 immediately; after reset, a held button produces a fresh we after the debounce latency.
